// File: rtl/k005297_dlcmp_if.sv
// Counter-side bus of the k005297 data-length comparator.
// Carries the clock enable, slot strobes, counter taps, target length and comparator status.
interface k005297_dlcmp_if;
  logic        i_CLK2M_PCEN_n;
  logic [19:0] i_ROT20_n;
  logic        i_DLCNT_START_n;
  logic [9:0]  i_TARGET_LEN;
  logic        i_DLCNTR_LSB;
  logic        i_DLCNTR_CFLAG;
  logic        o_SUPBD_START_n;
  logic        o_DLEQ;
  logic        o_DLOVF;
  logic        o_BUSY;
  logic [9:0]  o_DLCNT_RB;

  modport master (
    output i_CLK2M_PCEN_n,
    output i_ROT20_n,
    output i_DLCNT_START_n,
    output i_TARGET_LEN,
    output i_DLCNTR_LSB,
    output i_DLCNTR_CFLAG,
    input  o_SUPBD_START_n,
    input  o_DLEQ,
    input  o_DLOVF,
    input  o_BUSY,
    input  o_DLCNT_RB
  );

  modport slave (
    input  i_CLK2M_PCEN_n,
    input  i_ROT20_n,
    input  i_DLCNT_START_n,
    input  i_TARGET_LEN,
    input  i_DLCNTR_LSB,
    input  i_DLCNTR_CFLAG,
    output o_SUPBD_START_n,
    output o_DLEQ,
    output o_DLOVF,
    output o_BUSY,
    output o_DLCNT_RB
  );
endinterface

// File: rtl/k005297_dlcmp.sv
// Serial data-length comparator: deserialises the counter over slots 0-9, compares at slot 10, strobes end at slot 11.
// Optional macro K005297_DLCMP_READBACK_EN builds the o_DLCNT_RB readback register (tied to 0 otherwise).
module k005297_dlcmp (
  input  logic             i_MCLK,
  input  logic             i_MRST_n,
  k005297_dlcmp_if.slave   bus
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARMED,
    ST_CAPTURE,
    ST_EVAL,
    ST_DONE
  } state_t;

  state_t     state_q, state_d;
  logic [9:0] tgt_q, tgt_d;
  logic [9:0] cap_q, cap_d;
  logic       supbd_n_q, supbd_n_d;
  logic       dleq_q, dleq_d;
  logic       dlovf_q, dlovf_d;
  logic       busy_q, busy_d;
  logic       strobe_sent_q, strobe_sent_d;

  logic       slot_vld;
  logic [4:0] slot;
  logic       adv;
  logic       start;
  logic       eval_fire;

  // Lowest active-low strobe wins; with no strobe low there is no slot and nothing advances.
  always_comb begin
    slot_vld = 1'b0;
    slot     = 5'd0;
    for (int k = 19; k >= 0; k--) begin
      if (!bus.i_ROT20_n[k]) begin
        slot_vld = 1'b1;
        slot     = 5'(k);
      end
    end
  end

  assign adv       = !bus.i_CLK2M_PCEN_n && slot_vld;
  assign start     = !bus.i_DLCNT_START_n;
  assign eval_fire = adv && !start && (state_q == ST_EVAL) && (slot == 5'd10);

  always_comb begin
    state_d       = state_q;
    tgt_d         = tgt_q;
    cap_d         = cap_q;
    supbd_n_d     = supbd_n_q;
    dleq_d        = dleq_q;
    dlovf_d       = dlovf_q;
    strobe_sent_d = strobe_sent_q;

    if (adv) begin
      supbd_n_d = 1'b1;
      if (start) begin
        tgt_d   = bus.i_TARGET_LEN;
        cap_d   = '0;
        dleq_d  = 1'b0;
        dlovf_d = 1'b0;
        state_d = ST_ARMED;
      end else begin
        case (state_q)
          ST_ARMED: begin
            if (slot == 5'd0) begin
              cap_d[0] = bus.i_DLCNTR_LSB;
              state_d  = ST_CAPTURE;
            end
          end
          ST_CAPTURE: begin
            for (int b = 0; b < 10; b++) begin
              if (slot == 5'(b)) cap_d[b] = bus.i_DLCNTR_LSB;
            end
            if (slot == 5'd9) state_d = ST_EVAL;
          end
          ST_EVAL: begin
            if (slot == 5'd10) begin
              if (bus.i_DLCNTR_CFLAG) dlovf_d = 1'b1;
              // Plain 10-bit compare: a wrapped counter is still compared, wrap only shows on DLOVF.
              if (cap_q == tgt_q) begin
                dleq_d        = 1'b1;
                strobe_sent_d = 1'b0;
                state_d       = ST_DONE;
              end else begin
                state_d = ST_ARMED;
              end
            end
          end
          ST_DONE: begin
            if ((slot == 5'd11) && !strobe_sent_q) begin
              supbd_n_d     = 1'b0;
              strobe_sent_d = 1'b1;
            end
          end
          default: ;
        endcase
      end
    end

    busy_d = (state_d == ST_ARMED) || (state_d == ST_CAPTURE) || (state_d == ST_EVAL);
  end

  always_ff @(posedge i_MCLK or negedge i_MRST_n) begin
    if (!i_MRST_n) begin
      state_q       <= ST_IDLE;
      tgt_q         <= '0;
      cap_q         <= '0;
      supbd_n_q     <= 1'b1;
      dleq_q        <= 1'b0;
      dlovf_q       <= 1'b0;
      busy_q        <= 1'b0;
      strobe_sent_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      tgt_q         <= tgt_d;
      cap_q         <= cap_d;
      supbd_n_q     <= supbd_n_d;
      dleq_q        <= dleq_d;
      dlovf_q       <= dlovf_d;
      busy_q        <= busy_d;
      strobe_sent_q <= strobe_sent_d;
    end
  end

`ifdef K005297_DLCMP_READBACK_EN
  logic [9:0] rb_q, rb_d;

  always_comb begin
    rb_d = rb_q;
    if (eval_fire) rb_d = cap_q;
  end

  always_ff @(posedge i_MCLK or negedge i_MRST_n) begin
    if (!i_MRST_n) rb_q <= '0;
    else           rb_q <= rb_d;
  end

  assign bus.o_DLCNT_RB = rb_q;
`else
  logic unused_eval_fire;
  assign unused_eval_fire = eval_fire;
  assign bus.o_DLCNT_RB   = '0;
`endif

  assign bus.o_SUPBD_START_n = supbd_n_q;
  assign bus.o_DLEQ          = dleq_q;
  assign bus.o_DLOVF         = dlovf_q;
  assign bus.o_BUSY          = busy_q;

endmodule
